ff_latch: RTL and testbench



---
 rtl/ff_latch.sv | 50 +++++
 tb/tb_ff_latch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ff_latch.sv
// ff_latch
//
// Storage-cell pair fed from one data input and one clock:
//   - a level-sensitive latch, transparent while clk is low, opaque while high
//   - a rising-edge flip-flop
// Both cells clear asynchronously while rst_n is low. Every bit is an
// independent latch/flop pair; there is no cross-bit logic.
//
// Parameters
//   WIDTH    width of d, q_latch and q_ff
//
// Ports
//   clk      in   1      latch enable (transparent at 0) and flop capture clock
//   rst_n    in   1      asynchronous active-low clear of both cells
//   d        in   WIDTH  shared data input
//   q_latch  out  WIDTH  latch output
//   q_ff     out  WIDTH  flop output

module ff_latch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_latch,
  output logic [WIDTH-1:0] q_ff
);

  // Reset has priority over the enable so the latch reads zero while rst_n is
  // low, and after release with clk high it keeps holding that zero until clk
  // falls and the latch reopens.
  always_latch begin
    if (!rst_n) begin
      q_latch <= '0;
    end else if (!clk) begin
      q_latch <= d;
    end
  end

  // A rising edge coincident with release sees rst_n still low and keeps zero,
  // so the first capture is on the first edge strictly after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ff <= '0;
    end else begin
      q_ff <= d;
    end
  end

endmodule

// File: tb/tb_ff_latch.sv
module tb_ff_latch;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q_latch;
  logic [WIDTH-1:0] q_ff;

  ff_latch #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .q_latch (q_latch),
    .q_ff    (q_ff)
  );

  typedef struct {
    string            name;
    logic [WIDTH-1:0] exp_latch;
    logic [WIDTH-1:0] exp_ff;
  } exp_t;

  exp_t sb[$];
  logic obs;
  int   vectors;
  int   miscompares;

  // Monitor: each observation strobe pops one expected response and compares
  // it against what the DUT is presenting at that moment.
  always @(posedge obs) begin
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %-14s no expected entry queued", "scoreboard");
    end else begin
      e = sb.pop_front();
      vectors++;
      if (q_latch !== e.exp_latch || q_ff !== e.exp_ff) begin
        miscompares++;
        $display("FAIL %-14s q_latch=%h q_ff=%h, required q_latch=%h q_ff=%h",
                 e.name, q_latch, q_ff, e.exp_latch, e.exp_ff);
      end
    end
  end

  // Let the inputs settle, queue the expected response, then strobe the monitor.
  task automatic expect_out(input string name, input logic [WIDTH-1:0] el,
                            input logic [WIDTH-1:0] ef);
    exp_t e;
    #1;
    e.name = name;
    e.exp_latch = el;
    e.exp_ff = ef;
    sb.push_back(e);
    obs = 1'b1;
    #1;
    obs = 1'b0;
    #3;
  endtask

  task automatic set_clk(input logic v);
    #5 clk = v;
  endtask

  task automatic set_d(input logic [WIDTH-1:0] v);
    #5 d = v;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    obs = 1'b0;
    clk = 1'b0;
    rst_n = 1'b0;
    d = 4'hF;

    // Reset holds both outputs at zero regardless of clk and d
    expect_out("rst_hold", 4'h0, 4'h0);
    set_clk(1'b1);
    expect_out("rst_clk_hi", 4'h0, 4'h0);
    set_clk(1'b0);
    expect_out("rst_clk_lo", 4'h0, 4'h0);

    // Release with clk low: latch transparent at once, flop still zero
    #5 rst_n = 1'b1;
    expect_out("rel_clk_lo", 4'hF, 4'h0);

    // Transparent phase
    set_d(4'h0); expect_out("transp_0", 4'h0, 4'h0);
    set_d(4'h5); expect_out("transp_5", 4'h5, 4'h0);
    set_d(4'hA); expect_out("transp_a", 4'hA, 4'h0);
    set_d(4'hF); expect_out("transp_f", 4'hF, 4'h0);

    // Opaque phase: rise with d=9, then toggle d
    set_d(4'h9);
    set_clk(1'b1); expect_out("opaque_edge", 4'h9, 4'h9);
    set_d(4'h0); expect_out("opaque_d0", 4'h9, 4'h9);
    set_d(4'h6); expect_out("opaque_d6", 4'h9, 4'h9);
    set_d(4'hF); expect_out("opaque_df", 4'h9, 4'h9);

    // Capture 0
    set_d(4'h0); expect_out("cap0_hi", 4'h9, 4'h9);
    set_clk(1'b0); expect_out("cap0_fall", 4'h0, 4'h9);
    set_clk(1'b1); expect_out("cap0_rise", 4'h0, 4'h0);

    // Capture all-ones twice, then zero
    set_d(4'hF);
    set_clk(1'b0); expect_out("cap1a_fall", 4'hF, 4'h0);
    set_clk(1'b1); expect_out("cap1a_rise", 4'hF, 4'hF);
    set_clk(1'b0); expect_out("cap1b_fall", 4'hF, 4'hF);
    set_clk(1'b1); expect_out("cap1b_rise", 4'hF, 4'hF);
    set_d(4'h0);
    set_clk(1'b0); expect_out("cap0b_fall", 4'h0, 4'hF);
    set_clk(1'b1); expect_out("cap0b_rise", 4'h0, 4'h0);

    // Mixed bit pattern confirms per-bit independence
    set_d(4'h3);
    set_clk(1'b0); expect_out("mix_fall", 4'h3, 4'h0);
    set_clk(1'b1); expect_out("mix_rise", 4'h3, 4'h3);
    set_d(4'hC);
    set_clk(1'b0); expect_out("mix2_fall", 4'hC, 4'h3);
    set_clk(1'b1); expect_out("mix2_rise", 4'hC, 4'hC);

    // Async reset with clk high and both outputs at all-ones
    set_d(4'hF);
    set_clk(1'b0);
    set_clk(1'b1); expect_out("pre_rst", 4'hF, 4'hF);
    #5 rst_n = 1'b0;
    expect_out("arst_clk_hi", 4'h0, 4'h0);
    #5 rst_n = 1'b1;
    expect_out("rel_clk_hi", 4'h0, 4'h0);
    set_d(4'h5); expect_out("rel_hold", 4'h0, 4'h0);
    set_clk(1'b0); expect_out("rel_fall", 4'h5, 4'h0);
    set_clk(1'b1); expect_out("rel_rise", 4'h5, 4'h5);

    // Async reset with clk low mid-operation
    set_clk(1'b0);
    #5 rst_n = 1'b0;
    expect_out("arst_clk_lo", 4'h0, 4'h0);
    set_d(4'hA); expect_out("arst_d_chg", 4'h0, 4'h0);
    #5 rst_n = 1'b1;
    expect_out("rel2_clk_lo", 4'hA, 4'h0);
    set_clk(1'b1); expect_out("rel2_rise", 4'hA, 4'hA);

    #10;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %-14s %0d entries left unchecked, required 0", "sb_drain", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL %-14s simulation time limit reached", "timeout");
    $fatal(1, "time limit");
  end

endmodule
